// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, synchronous-memory fetch and skid-buffered delivery to decode
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [WIDTH-1:0]      HALT_WORD  = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [WIDTH-1:0]      mem_instruction,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_instruction,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted,
    output logic [15:0]           instr_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_pc;

    logic                  skid_valid;
    logic [WIDTH-1:0]      skid_instruction;
    logic [ADDR_WIDTH-1:0] skid_pc;

    logic                  issue;
    logic                  xfer;
    logic                  ret_halt;
    logic                  ret_word;

    // The memory answers one cycle after an issue, so inflight marks a return this cycle.
    assign xfer        = out_valid && out_ready;
    assign ret_halt    = inflight && (mem_instruction == HALT_WORD);
    assign ret_word    = inflight && (mem_instruction != HALT_WORD);
    assign mem_address = fetch_pc;
    assign halted      = (state == S_HALTED);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and issue decision; a returning HALT_WORD cancels this cycle's issue,
    // and a redirect overrides everything else.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ret_halt) begin
                    state_next = S_HALTED;
                end else begin
                    // Stop issuing when the word coming back could find no free slot.
                    issue = !skid_valid && !(out_valid && !out_ready && inflight);
                end
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (redirect_valid) begin
            state_next = S_FETCH;
            issue      = 1'b0;
        end
    end

    // Program counter and in-flight tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
            end
        end
    end

    // Output register and skid: returns land in the output register when it frees up,
    // otherwise in the skid, and the skid always drains first to keep PC order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            out_instruction  <= '0;
            out_pc           <= '0;
            skid_valid       <= 1'b0;
            skid_instruction <= '0;
            skid_pc          <= '0;
        end else if (redirect_valid) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (xfer) begin
            if (skid_valid) begin
                out_instruction <= skid_instruction;
                out_pc          <= skid_pc;
                if (ret_word) begin
                    skid_instruction <= mem_instruction;
                    skid_pc          <= inflight_pc;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (ret_word) begin
                out_instruction <= mem_instruction;
                out_pc          <= inflight_pc;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (!out_valid) begin
            if (ret_word) begin
                out_valid       <= 1'b1;
                out_instruction <= mem_instruction;
                out_pc          <= inflight_pc;
            end
        end else if (ret_word) begin
            skid_valid       <= 1'b1;
            skid_instruction <= mem_instruction;
            skid_pc          <= inflight_pc;
        end
    end

    // Completed-transfer counter, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= '0;
        end else if (xfer) begin
            instr_count <= instr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed bench for fetch_sequencer against a PC-order delivery model
module tb_fetch_sequencer;

    localparam int          AW   = 12;
    localparam int          W    = 32;
    localparam logic [31:0] HALT = 32'h8000_0000;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] mem_address;
    logic [W-1:0]  mem_instruction;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_instruction;
    logic [AW-1:0] out_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halted;
    logic [15:0]   instr_count;

    logic [W-1:0]  mem [0:4095];

    int            total;
    int            bad;

    logic [AW-1:0] m_pc;
    logic          m_active;
    logic          m_idle;
    logic [15:0]   m_count;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mem_address    (mem_address),
        .mem_instruction(mem_instruction),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instruction(out_instruction),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) mem_instruction <= mem[mem_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h1;
        return w;
    endfunction

    // One clock: sample what the edge sees, advance, then score the edge against the model.
    task automatic tick();
        logic          v, r, rd, rs, st;
        logic [AW-1:0] p, rpc;
        logic [W-1:0]  ins;
        v = out_valid; r = out_ready; rd = redirect_valid; rs = rst; st = start;
        p = out_pc; ins = out_instruction; rpc = redirect_pc;
        @(posedge clk);
        #1;
        if (rs) begin
            m_count  = 0;
            m_active = 0;
            m_idle   = 1;
            m_pc     = 0;
        end else begin
            if (v === 1'b1 && r) begin
                chk("deliver_allowed", {31'd0, m_active && (mem[m_pc] != HALT)}, 1);
                chk("deliver_pc", {20'd0, p}, {20'd0, m_pc});
                chk("deliver_instr", ins, mem[m_pc]);
                m_pc    = m_pc + 12'd1;
                m_count = m_count + 16'd1;
            end else if (v === 1'b1 && !rd) begin
                chk("stall_valid", {31'd0, out_valid}, 1);
                chk("stall_pc", {20'd0, out_pc}, {20'd0, p});
                chk("stall_instr", out_instruction, ins);
            end
            if (rd) begin
                m_pc     = rpc;
                m_active = 1;
                m_idle   = 0;
            end else if (st && m_idle) begin
                m_pc     = 0;
                m_active = 1;
                m_idle   = 0;
            end
        end
        chk("instr_count", {16'd0, instr_count}, {16'd0, m_count});
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!(halted && !out_valid) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, {31'd0, halted && !out_valid}, 1);
        chk({tag, "_complete"}, {31'd0, mem[m_pc] == HALT}, 1);
    endtask

    task automatic do_redirect(input logic [AW-1:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        out_ready      = 1'b0;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int            n;
        logic [AW-1:0] held_addr;
        total = 0; bad = 0;
        m_pc = 0; m_active = 0; m_idle = 1; m_count = 0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        held_addr = '0;
        for (int i = 0; i < 4096; i++) mem[i] = rnd_word();
        mem[0] = 32'h0000A083; mem[1] = 32'h0000A103;
        mem[2] = 32'h002080B3; mem[3] = 32'h40208233;
        mem[4] = HALT;         mem[5] = 32'h00208133;
        mem[12'h020] = HALT;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_count", {16'd0, instr_count}, 0);
        chk("rst_addr", {20'd0, mem_address}, 0);
        chk("rst_pc", {20'd0, out_pc}, 0);
        chk("rst_instr", out_instruction, 0);

        // Start latency and straight-line run into HALT at pc 4
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("lat_e1", {31'd0, out_valid}, 0);
        tick();
        chk("lat_e2", {31'd0, out_valid}, 0);
        tick();
        chk("lat_e3", {31'd0, out_valid}, 1);
        chk("lat_pc", {20'd0, out_pc}, 0);
        drain("run4", 100);
        chk("run4_count", {16'd0, instr_count}, 4);
        chk("run4_halted", {31'd0, halted}, 1);
        chk("halt_fetch_pc", {20'd0, mem_address}, 5);

        // Decode stall with pc 1 in the output register
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (m_count != 16'd1 && n < 10) begin tick(); n++; end
        chk("stall_reach", {16'd0, m_count}, 1);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_hold_valid", {31'd0, out_valid}, 1);
            chk("stall_hold_pc", {20'd0, out_pc}, 1);
            chk("stall_hold_instr", out_instruction, mem[1]);
            if (k == 1) held_addr = mem_address;
            if (k >= 2) chk("stall_addr_hold", {20'd0, mem_address}, {20'd0, held_addr});
        end
        drain("stall", 100);
        chk("stall_count", {16'd0, instr_count}, 4);

        // Redirect while pc 2 sits undelivered
        do_redirect(12'h000);
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_pc == 12'd2) && n < 20) begin tick(); n++; end
        chk("rd_reach_pc2", {31'd0, out_valid && out_pc == 12'd2}, 1);
        out_ready = 1'b0;
        tick(); tick();
        do_redirect(12'h010);
        chk("rd_flush", {31'd0, out_valid}, 0);
        out_ready = 1'b1;
        tick();
        chk("rd_lat1", {31'd0, out_valid}, 0);
        tick();
        chk("rd_lat2", {31'd0, out_valid}, 1);
        chk("rd_first_pc", {20'd0, out_pc}, 12'h010);
        tick();
        chk("rd_second_pc", {20'd0, out_pc}, 12'h011);
        drain("redir", 200);

        // Redirect near the top of memory wraps to 0
        do_redirect(12'hFFE);
        out_ready = 1'b1;
        tick(); tick();
        chk("wrap_pc0", {20'd0, out_pc}, 12'hFFE);
        tick();
        chk("wrap_pc1", {20'd0, out_pc}, 12'hFFF);
        tick();
        chk("wrap_pc2", {20'd0, out_pc}, 12'h000);
        drain("wrap", 100);

        // Reset in the middle of a stream
        do_redirect(12'h100);
        out_ready = 1'b1;
        tick(); tick();
        chk("mid_valid", {31'd0, out_valid}, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_halted", {31'd0, halted}, 0);
        chk("mid_rst_count", {16'd0, instr_count}, 0);
        chk("mid_rst_addr", {20'd0, mem_address}, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_idle_valid", {31'd0, out_valid}, 0);
        end
        start = 1'b1; tick(); start = 1'b0;
        drain("mid", 100);
        chk("mid_count", {16'd0, instr_count}, 4);

        // Random traffic over a program with one HALT per 64-word block
        for (int i = 0; i < 4096; i++) mem[i] = rnd_word();
        for (int b = 0; b < 64; b++) mem[b * 64 + $urandom_range(63)] = HALT;
        for (int c = 0; c < 2500; c++) begin
            redirect_valid = 1'b0;
            start = 1'b0;
            out_ready = ($urandom_range(3) != 0);
            if ((halted && !out_valid) || $urandom_range(59) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = AW'($urandom_range(4095));
                out_ready      = 1'b0;
            end
            if ($urandom_range(29) == 0) start = 1'b1;
            tick();
        end
        redirect_valid = 1'b0;
        start = 1'b0;
        drain("rand", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
